// File: rtl/flash_read_fsm.sv
// Sequential flash read controller: one Avalon-style read per start pulse, capture, advance word address.
// Optional read abort after TIMEOUT_CYCLES wait cycles is compiled in with `define FLASH_READ_TIMEOUT_EN.
module flash_read_fsm #(
  parameter int ADDR_W         = 23,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              readdatavalid,
  input  logic [DATA_W-1:0] readdata,
  output logic              read,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data,
  output logic              data_en,
  output logic              gen_addr,
  output logic              timeout
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              read_q, data_en_q, gen_addr_q;
  logic              capture;
  logic              expire;

`ifdef FLASH_READ_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] wait_cnt_q;
  logic             timeout_q;

  // The counter holds k-1 during the k-th WAIT cycle, so this flags the last allowed one.
  assign expire = (state_q == WAIT) && (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign expire = 1'b0;
`endif

  assign capture = ((state_q == REQ) || (state_q == WAIT)) && readdatavalid;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = REQ;
      REQ:     state_d = readdatavalid ? DONE : WAIT;
      WAIT: begin
        if (readdatavalid)  state_d = DONE;
        else if (expire)    state_d = IDLE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q (Moore).
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      data_q     <= '0;
      read_q     <= 1'b0;
      data_en_q  <= 1'b0;
      gen_addr_q <= 1'b0;
`ifdef FLASH_READ_TIMEOUT_EN
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      read_q     <= (state_d == REQ);
      data_en_q  <= (state_d == DONE);
      gen_addr_q <= (state_d == DONE);
      if (capture)    data_q <= readdata;
      if (gen_addr_q) addr_q <= addr_q + 1'b1;
`ifdef FLASH_READ_TIMEOUT_EN
      if (state_d == REQ)       wait_cnt_q <= '0;
      else if (state_q == WAIT) wait_cnt_q <= wait_cnt_q + 1'b1;
      timeout_q <= expire && !readdatavalid;
`endif
    end
  end

  assign read     = read_q;
  assign addr     = addr_q;
  assign data     = data_q;
  assign data_en  = data_en_q;
  assign gen_addr = gen_addr_q;
`ifdef FLASH_READ_TIMEOUT_EN
  assign timeout  = timeout_q;
`else
  assign timeout  = 1'b0;
`endif

endmodule

// File: tb/tb_flash_read_fsm.sv
// Directed, table-driven bench for flash_read_fsm (ADDR_W=4 so the address wrap is reachable).
module tb_flash_read_fsm;
  localparam int AW = 4;
  localparam int DW = 32;
  localparam int TO = 8;
`ifdef FLASH_READ_TIMEOUT_EN
  localparam int SINGLE_WAIT = 5;
  localparam int RDV_PERIOD  = 7;
`else
  localparam int SINGLE_WAIT = 10;
  localparam int RDV_PERIOD  = 11;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          readdatavalid = 1'b0;
  logic [DW-1:0] readdata = '0;
  logic          read, data_en, gen_addr, timeout;
  logic [AW-1:0] addr;
  logic [DW-1:0] data;

  int n_chk = 0;
  int n_err = 0;

  flash_read_fsm #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .readdatavalid(readdatavalid), .readdata(readdata),
    .read(read), .addr(addr), .data(data), .data_en(data_en), .gen_addr(gen_addr), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          st;
    logic          rdv;
    logic [DW-1:0] rd;
    logic          e_read;
    logic          e_den;
    logic          e_gen;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data;
  } vec_t;

  vec_t tbl[13];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_outs(input string tag, input logic e_rd, input logic e_de, input logic e_ga,
                          input logic [AW-1:0] e_ad, input logic [DW-1:0] e_da);
    chk({tag, ".read"}, 64'(read), 64'(e_rd));
    chk({tag, ".data_en"}, 64'(data_en), 64'(e_de));
    chk({tag, ".gen_addr"}, 64'(gen_addr), 64'(e_ga));
    chk({tag, ".addr"}, 64'(addr), 64'(e_ad));
    chk({tag, ".data"}, 64'(data), 64'(e_da));
    chk({tag, ".timeout"}, 64'(timeout), 64'(1'b0));
  endtask

  // Fast read: REQ, readdatavalid in REQ, DONE, back to IDLE.
  task automatic quick_read(input logic [DW-1:0] d);
    start = 1'b1; tick();
    start = 1'b0; readdatavalid = 1'b1; readdata = d; tick();
    readdatavalid = 1'b0; tick();
  endtask

  initial begin
    logic [AW-1:0] a0;
    logic [DW-1:0] d0, exp_d;
    int n_read, n_de;
    logic inflight, got;

    tbl[0]  = '{1'b0, 1'b1, 32'hAAAA0000, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0};
    tbl[1]  = '{1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 4'd0, 32'h0};
    tbl[2]  = '{1'b0, 1'b1, 32'h11111111, 1'b0, 1'b1, 1'b1, 4'd0, 32'h11111111};
    tbl[3]  = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 4'd1, 32'h11111111};
    tbl[4]  = '{1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 4'd1, 32'h11111111};
    tbl[5]  = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 4'd1, 32'h11111111};
    tbl[6]  = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 4'd1, 32'h11111111};
    tbl[7]  = '{1'b0, 1'b1, 32'h22222222, 1'b0, 1'b1, 1'b1, 4'd1, 32'h22222222};
    tbl[8]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 4'd2, 32'h22222222};
    tbl[9]  = '{1'b0, 1'b1, 32'h33333333, 1'b0, 1'b0, 1'b0, 4'd2, 32'h22222222};
    tbl[10] = '{1'b1, 1'b1, 32'h44444444, 1'b1, 1'b0, 1'b0, 4'd2, 32'h22222222};
    tbl[11] = '{1'b0, 1'b1, 32'h55555555, 1'b0, 1'b1, 1'b1, 4'd2, 32'h55555555};
    tbl[12] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 4'd3, 32'h55555555};

    // Reset state
    tick(); tick();
    chk_outs("reset", 1'b0, 1'b0, 1'b0, '0, '0);
    rst = 1'b1;

    // Vector table: one row per clock cycle
    for (int i = 0; i < 13; i++) begin
      start = tbl[i].st; readdatavalid = tbl[i].rdv; readdata = tbl[i].rd;
      tick();
      chk_outs($sformatf("vec%0d", i), tbl[i].e_read, tbl[i].e_den, tbl[i].e_gen,
               tbl[i].e_addr, tbl[i].e_data);
    end
    start = 1'b0; readdatavalid = 1'b0;

    // start held high through WAIT: exactly one read
    a0 = addr; n_read = 0;
    start = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (read) n_read++;
    end
    readdatavalid = 1'b1; readdata = 32'h0BADF00D; tick();
    chk("held.data_en", 64'(data_en), 64'(1'b1));
    start = 1'b0; readdatavalid = 1'b0; tick();
    chk("held.reads", 64'(n_read), 64'd1);
    chk("held.addr", 64'(addr), 64'(AW'(a0 + 1'b1)));

    // Single read with a long wait for readdatavalid
    a0 = addr; n_read = 0;
    start = 1'b1; tick(); start = 1'b0;
    chk("single.read", 64'(read), 64'(1'b1));
    chk("single.addr_req", 64'(addr), 64'(a0));
    for (int i = 0; i < SINGLE_WAIT - 1; i++) begin
      tick();
      if (read || data_en) n_read++;
    end
    chk("single.quiet_wait", 64'(n_read), 64'd0);
    readdatavalid = 1'b1; readdata = 32'hDEADBEEF; tick();
    readdatavalid = 1'b0; readdata = 32'h0;
    chk_outs("single.done", 1'b0, 1'b1, 1'b1, a0, 32'hDEADBEEF);
    tick();
    chk_outs("single.after", 1'b0, 1'b0, 1'b0, AW'(a0 + 1'b1), 32'hDEADBEEF);

    // Repeated: start every 5 cycles, readdatavalid every RDV_PERIOD cycles
    a0 = addr; n_read = 0; n_de = 0; inflight = 1'b0; got = 1'b0; exp_d = '0;
    for (int cyc = 0; cyc < 140; cyc++) begin
      start = (cyc < 100) && (cyc % 5 == 0);
      readdatavalid = (cyc % RDV_PERIOD == RDV_PERIOD - 1);
      readdata = 32'hC0DE0000 + 32'(cyc);
      if (readdatavalid && inflight && !got) begin exp_d = readdata; got = 1'b1; end
      tick();
      if (read) begin
        if (inflight) chk("rep.overlap", 64'd1, 64'd0);
        inflight = 1'b1; got = 1'b0; n_read++;
      end
      if (data_en) begin
        chk("rep.data", 64'(data), 64'(exp_d));
        chk("rep.inflight", 64'(inflight && got), 64'd1);
        inflight = 1'b0; n_de++;
      end
    end
    start = 1'b0; readdatavalid = 1'b0;
    chk("rep.read_eq_den", 64'(n_read), 64'(n_de));
    chk("rep.some_done", 64'(n_de > 0), 64'd1);
    chk("rep.some_ignored", 64'(n_read < 20), 64'd1);
    chk("rep.addr", 64'(addr), 64'(AW'(32'(a0) + n_de)));

`ifdef FLASH_READ_TIMEOUT_EN
    // Abort after TO wait cycles
    a0 = addr; d0 = data;
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < TO; i++) begin
      tick();
      chk("to.early", 64'(timeout), 64'd0);
    end
    tick();
    chk("to.pulse", 64'(timeout), 64'd1);
    chk("to.addr", 64'(addr), 64'(a0));
    chk("to.data", 64'(data), 64'(d0));
    chk("to.den", 64'(data_en | gen_addr), 64'd0);
    tick();
    chk("to.once", 64'(timeout), 64'd0);
    start = 1'b1; tick(); start = 1'b0;
    chk("to.reissue", 64'({read, addr}), 64'({1'b1, a0}));
    // readdatavalid in the expiry cycle wins
    for (int i = 0; i < TO; i++) tick();
    readdatavalid = 1'b1; readdata = 32'h7E570000; tick(); readdatavalid = 1'b0;
    chk("to.race_den", 64'(data_en), 64'd1);
    chk("to.race_data", 64'(data), 64'h7E570000);
    tick();
    chk("to.race_nopulse", 64'(timeout), 64'd0);
    chk("to.race_addr", 64'(addr), 64'(AW'(a0 + 1'b1)));
`else
    // Without the abort feature WAIT is held as long as needed
    a0 = addr; n_read = 0;
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (timeout || data_en || read) n_read++;
    end
    chk("hold.quiet", 64'(n_read), 64'd0);
    readdatavalid = 1'b1; readdata = 32'h600DCAFE; tick(); readdatavalid = 1'b0;
    chk("hold.done", 64'({data_en, data}), 64'({1'b1, 32'h600DCAFE}));
    tick();
`endif

    // Reset mid-flight, late readdatavalid ignored
    start = 1'b1; tick(); start = 1'b0; tick();
    rst = 1'b0; tick(); tick();
    chk_outs("rst_mid", 1'b0, 1'b0, 1'b0, '0, '0);
    rst = 1'b1; readdatavalid = 1'b1; readdata = 32'hFFFF0000; tick();
    readdatavalid = 1'b0; tick();
    chk_outs("rst_late", 1'b0, 1'b0, 1'b0, '0, '0);

    // Address wrap: 15 reads to reach 15, one more wraps to 0
    for (int i = 0; i < 15; i++) quick_read(32'(i + 1));
    chk("wrap.pre", 64'(addr), 64'd15);
    chk("wrap.data", 64'(data), 64'd15);
    start = 1'b1; tick(); start = 1'b0;
    chk("wrap.req_addr", 64'({read, addr}), 64'({1'b1, 4'd15}));
    readdatavalid = 1'b1; readdata = 32'hA5A5A5A5; tick(); readdatavalid = 1'b0;
    chk("wrap.done", 64'({data_en, gen_addr}), 64'd3);
    tick();
    chk("wrap.addr0", 64'(addr), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
